// File: rtl/bsx_stream_prefetch.sv
// bsx_stream_prefetch: round-robin prefetcher feeding two BS-X stream channels from one byte-wide memory port
module bsx_stream_prefetch #(
    parameter logic [23:0] BASE_ADDR = 24'hE00000,
    parameter int          DEPTH     = 4,
    parameter logic [8:0]  START_OFF = 9'h048
) (
    input  logic        clkin,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  ch_load,
    input  logic [9:0]  ch_page0,
    input  logic [9:0]  ch_page1,
    input  logic [1:0]  ch_pop,
    output logic [7:0]  ch_data0,
    output logic [7:0]  ch_data1,
    output logic [1:0]  ch_valid,
    output logic [1:0]  ch_underrun,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          stale_q, stale_d;
    logic          rr_q, rr_d;
    logic          mem_req_q, mem_req_d;
    logic [23:0]   mem_addr_q, mem_addr_d;
    logic [9:0]    page_q [2];
    logic [9:0]    page_d [2];
    logic [8:0]    off_q [2];
    logic [8:0]    off_d [2];
    logic [1:0]    done_q, done_d;
    logic [1:0]    underrun_q, underrun_d;
    logic [AW-1:0] rd_q [2];
    logic [AW-1:0] rd_d [2];
    logic [AW-1:0] wr_q [2];
    logic [AW-1:0] wr_d [2];
    logic [AW:0]   cnt_q [2];
    logic [AW:0]   cnt_d [2];
    logic [7:0]    fifo_q [2][DEPTH];
    logic [7:0]    fifo_d [2][DEPTH];
    logic [1:0]    need, push, pop_ok;
    logic          gsel;

    // A channel wants a byte when it is streaming and its FIFO can still absorb every byte in flight
    always_comb begin
        for (int c = 0; c < 2; c++)
            need[c] = enable && page_q[c] != 10'd0 && !done_q[c] &&
                      (cnt_q[c] + ((state_q == WAIT && gnt_q == 1'(c) && !stale_q) ? (AW+1)'(1) : '0)) < FULL;
        gsel = need[rr_q] ? rr_q : ~rr_q;
    end

    // Request controller: grant in IDLE, hold the request in WAIT until the ack
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        stale_d    = stale_q;
        rr_d       = rr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = '0;
        if (state_q == IDLE) begin
            if (|need) begin
                state_d    = WAIT;
                gnt_d      = gsel;
                stale_d    = ch_load[gsel];
                mem_req_d  = 1'b1;
                mem_addr_d = BASE_ADDR + {5'd0, page_q[gsel], off_q[gsel]};
            end
        end else if (mem_ack) begin
            state_d       = IDLE;
            mem_req_d     = 1'b0;
            rr_d          = ~gnt_q;
            push[gnt_q]   = !stale_q && !ch_load[gnt_q];
        end else begin
            stale_d = stale_q | ch_load[gnt_q];
        end
    end

    // Per-channel stream state and FIFO bookkeeping; a load overrides everything else on its channel
    always_comb begin
        page_d     = page_q;
        off_d      = off_q;
        done_d     = done_q;
        underrun_d = underrun_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        fifo_d     = fifo_q;
        pop_ok     = '0;
        for (int c = 0; c < 2; c++) begin
            pop_ok[c] = ch_pop[c] && cnt_q[c] != '0 && !ch_load[c];
            if (ch_load[c]) begin
                page_d[c]     = (c == 1) ? ch_page1 : ch_page0;
                off_d[c]      = START_OFF;
                done_d[c]     = 1'b0;
                underrun_d[c] = 1'b0;
                rd_d[c]       = '0;
                wr_d[c]       = '0;
                cnt_d[c]      = '0;
            end else begin
                if (ch_pop[c] && cnt_q[c] == '0)
                    underrun_d[c] = 1'b1;
                if (pop_ok[c])
                    rd_d[c] = rd_q[c] + AW'(1);
                if (push[c]) begin
                    fifo_d[c][wr_q[c]] = mem_rdata;
                    wr_d[c]            = wr_q[c] + AW'(1);
                    done_d[c]          = off_q[c] == 9'h1FF;
                    off_d[c]           = (off_q[c] == 9'h1FF) ? off_q[c] : off_q[c] + 9'd1;
                end
                cnt_d[c] = cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop_ok[c]);
            end
        end
    end

    // Control and pointer registers
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            stale_q    <= 1'b0;
            rr_q       <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= '0;
            underrun_q <= '0;
            for (int c = 0; c < 2; c++) begin
                page_q[c] <= '0;
                off_q[c]  <= START_OFF;
                rd_q[c]   <= '0;
                wr_q[c]   <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            stale_q    <= stale_d;
            rr_q       <= rr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            page_q     <= page_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    // FIFO storage needs no reset: contents are never exposed while empty
    always_ff @(posedge clkin) begin
        fifo_q <= fifo_d;
    end

    // Head bytes read as zero when empty or while BS-X mode is off
    always_comb begin
        ch_valid = {cnt_q[1] != '0, cnt_q[0] != '0};
        ch_data0 = (enable && ch_valid[0]) ? fifo_q[0][rd_q[0]] : 8'h00;
        ch_data1 = (enable && ch_valid[1]) ? fifo_q[1][rd_q[1]] : 8'h00;
    end

    assign ch_underrun = underrun_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_bsx_stream_prefetch.sv
// tb_bsx_stream_prefetch: directed bench with a queue-based reference model of the stream prefetcher
module tb_bsx_stream_prefetch;
    localparam int DEPTH = 4;

    logic        clkin = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [1:0]  ch_load = '0, ch_pop = '0;
    logic [9:0]  ch_page0 = '0, ch_page1 = '0;
    logic [7:0]  ch_data0, ch_data1;
    logic [1:0]  ch_valid, ch_underrun;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;

    bsx_stream_prefetch #(.BASE_ADDR(24'hE00000), .DEPTH(DEPTH), .START_OFF(9'h048)) dut (
        .clkin(clkin), .rst_n(rst_n), .enable(enable), .ch_load(ch_load),
        .ch_page0(ch_page0), .ch_page1(ch_page1), .ch_pop(ch_pop),
        .ch_data0(ch_data0), .ch_data1(ch_data1), .ch_valid(ch_valid),
        .ch_underrun(ch_underrun), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clkin = ~clkin;

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each channel is a page, a next offset and a byte queue; one request may be in flight
    logic [7:0]  q0[$], q1[$];
    int          m_page[2] = '{0, 0}, m_off[2] = '{'h48, 'h48};
    bit          m_done[2] = '{0, 0}, m_und[2] = '{0, 0};
    bit          busy = 0, ostale = 0;
    int          och = 0, last = 1, m_dch = -1, m_rr = 0;
    logic [7:0]  m_dd = '0;
    logic [23:0] oaddr = '0;

    function automatic int qsize(input int c);
        return c == 0 ? q0.size() : q1.size();
    endfunction

    function automatic bit needs(input int c);
        return enable && m_page[c] != 0 && !m_done[c] && qsize(c) < DEPTH;
    endfunction

    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete(); q1.delete();
            for (int c = 0; c < 2; c++) begin
                m_page[c] = 0; m_off[c] = 'h48; m_done[c] = 0; m_und[c] = 0;
            end
            busy = 0; ostale = 0; last = 1; och = 0; oaddr = '0;
        end else begin
            m_dch = -1;
            if (busy) begin
                if (ch_load[och]) ostale = 1;
                if (mem_ack) begin
                    if (!ostale) begin m_dch = och; m_dd = mem_rdata; end
                    busy = 0;
                    last = och;
                end
            end else if (needs(0) || needs(1)) begin
                m_rr   = 1 - last;
                och    = needs(m_rr) ? m_rr : 1 - m_rr;
                busy   = 1;
                ostale = ch_load[och];
                oaddr  = 24'hE00000 + 24'(m_page[och] * 512 + m_off[och]);
            end
            for (int c = 0; c < 2; c++) begin
                if (ch_load[c]) begin
                    if (c == 0) q0.delete(); else q1.delete();
                    m_page[c] = (c == 0) ? int'(ch_page0) : int'(ch_page1);
                    m_off[c] = 'h48; m_done[c] = 0; m_und[c] = 0;
                end else begin
                    if (ch_pop[c]) begin
                        if (qsize(c) > 0) begin
                            if (c == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        end else m_und[c] = 1;
                    end
                    if (m_dch == c) begin
                        if (c == 0) q0.push_back(m_dd); else q1.push_back(m_dd);
                        if (m_off[c] == 'h1FF) m_done[c] = 1; else m_off[c]++;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clkin) begin
        #3;
        check("valid", 32'(ch_valid), 32'({q1.size() != 0, q0.size() != 0}));
        check("data0", 32'(ch_data0), 32'((enable && q0.size() != 0) ? q0[0] : 8'h00));
        check("data1", 32'(ch_data1), 32'((enable && q1.size() != 0) ? q1[0] : 8'h00));
        check("underrun", 32'(ch_underrun), 32'({m_und[1], m_und[0]}));
        check("mem_req", 32'(mem_req), 32'(busy));
        if (busy) check("mem_addr", 32'(mem_addr), 32'(oaddr));
    end

    // Memory responder: logs each new request, acks after ack_dly cycles with addr-derived data
    logic [23:0] req_log[$];
    bit          auto_ack = 1, man_ack = 0, req_prev = 0;
    logic [7:0]  man_data = '0;
    int          ack_dly = 2, wcnt = 0;

    always @(negedge clkin) begin
        #1;
        if (mem_req && !req_prev) req_log.push_back(mem_addr);
        req_prev = mem_req;
        mem_ack  = 1'b0;
        if (man_ack) begin
            mem_ack = 1'b1; mem_rdata = man_data; man_ack = 0; wcnt = 0;
        end else if (mem_req && auto_ack) begin
            wcnt++;
            if (wcnt >= ack_dly) begin
                mem_ack = 1'b1; mem_rdata = mem_addr[7:0] ^ 8'hA5; wcnt = 0;
            end
        end else wcnt = 0;
    end

    task automatic load(input logic [1:0] m, input logic [9:0] p0, input logic [9:0] p1);
        ch_page0 = p0; ch_page1 = p1; ch_load = m;
        @(negedge clkin);
        ch_load = '0;
    endtask

    task automatic pop(input logic [1:0] m);
        ch_pop = m;
        @(negedge clkin);
        ch_pop = '0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!mem_req && k < 30) begin @(negedge clkin); k++; end
        check("wait_req", 32'(mem_req), 1);
    endtask

    initial begin
        repeat (3) @(negedge clkin);
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_valid", 32'(ch_valid), 0);
        check("rst_und", 32'(ch_underrun), 0);
        check("rst_data", 32'({ch_data1, ch_data0}), 0);
        rst_n = 1; enable = 1;
        @(negedge clkin);

        // Single channel fill
        ack_dly = 2; req_log.delete();
        load(2'b01, 10'h005, 10'h000);
        repeat (30) @(negedge clkin);
        check("fill_cnt", 32'(req_log.size()), 4);
        check("fill_a0", 32'(req_log[0]), 24'hE00A48);
        check("fill_a1", 32'(req_log[1]), 24'hE00A49);
        check("fill_a2", 32'(req_log[2]), 24'hE00A4A);
        check("fill_a3", 32'(req_log[3]), 24'hE00A4B);
        check("fill_req", 32'(mem_req), 0);
        check("fill_valid", 32'(ch_valid), 2'b01);
        check("fill_head", 32'(ch_data0), 8'hED);
        pop(2'b01);
        repeat (12) @(negedge clkin);
        check("refill_cnt", 32'(req_log.size()), 5);
        check("refill_a4", 32'(req_log[4]), 24'hE00A4C);
        check("refill_head", 32'(ch_data0), 8'hEC);

        // Round-robin from a fresh reset
        rst_n = 0; @(negedge clkin); rst_n = 1;
        req_log.delete();
        load(2'b11, 10'h001, 10'h002);
        repeat (40) @(negedge clkin);
        check("rr_cnt", 32'(req_log.size()), 8);
        check("rr_a0", 32'(req_log[0]), 24'hE00248);
        check("rr_a1", 32'(req_log[1]), 24'hE00448);
        check("rr_a2", 32'(req_log[2]), 24'hE00249);
        check("rr_a3", 32'(req_log[3]), 24'hE00449);

        // Stale flush
        auto_ack = 0;
        load(2'b11, 10'h000, 10'h003);
        wait_req();
        check("stale_a", 32'(mem_addr), 24'hE00648);
        load(2'b10, 10'h000, 10'h004);
        check("stale_hold_req", 32'(mem_req), 1);
        check("stale_hold_a", 32'(mem_addr), 24'hE00648);
        man_data = 8'h5A; man_ack = 1;
        repeat (2) @(negedge clkin);
        check("stale_drop", 32'(ch_valid[1]), 0);
        wait_req();
        check("stale_next", 32'(mem_addr), 24'hE00848);
        auto_ack = 1;
        repeat (20) @(negedge clkin);

        // Underrun, and load beating a simultaneous pop
        pop(2'b01);
        check("und_set", 32'(ch_underrun[0]), 1);
        check("und_data", 32'(ch_data0), 0);
        ch_page0 = '0; ch_load = 2'b01; ch_pop = 2'b01;
        @(negedge clkin);
        ch_load = '0; ch_pop = '0;
        check("und_loadpop", 32'(ch_underrun[0]), 0);
        pop(2'b01);
        check("und_set2", 32'(ch_underrun[0]), 1);
        load(2'b01, 10'h000, 10'h004);
        check("und_clr", 32'(ch_underrun[0]), 0);

        // End of page with continuous popping
        req_log.delete(); ack_dly = 1;
        load(2'b11, 10'h009, 10'h000);
        for (int k = 0; k < 3000; k++) begin
            ch_pop = {1'b0, ch_valid[0]};
            @(negedge clkin);
            if (req_log.size() >= 440 && !mem_req && !ch_valid[0]) break;
        end
        ch_pop = '0;
        check("eop_cnt", 32'(req_log.size()), 440);
        check("eop_first", 32'(req_log[0]), 24'hE01248);
        check("eop_1fe", 32'(req_log[438]), 24'hE013FE);
        check("eop_1ff", 32'(req_log[439]), 24'hE013FF);
        repeat (10) @(negedge clkin);
        check("eop_quiet", 32'(mem_req), 0);
        check("eop_cnt2", 32'(req_log.size()), 440);
        check("eop_nound", 32'(ch_underrun[0]), 0);
        pop(2'b01);
        check("eop_und", 32'(ch_underrun[0]), 1);

        // enable falling during WAIT
        req_log.delete(); ack_dly = 3;
        load(2'b10, 10'h000, 10'h002);
        wait_req();
        enable = 0;
        repeat (12) @(negedge clkin);
        check("en_cnt", 32'(req_log.size()), 1);
        check("en_req", 32'(mem_req), 0);
        check("en_valid", 32'(ch_valid[1]), 1);
        check("en_data", 32'(ch_data1), 0);
        enable = 1;
        @(negedge clkin);
        check("en_head", 32'(ch_data1), 8'hED);

        // Reset in the middle of a request
        auto_ack = 0;
        wait_req();
        #2 rst_n = 0;
        #1;
        check("arst_req", 32'(mem_req), 0);
        check("arst_valid", 32'(ch_valid), 0);
        repeat (3) @(negedge clkin);
        rst_n = 1; auto_ack = 1; req_log.delete();
        repeat (10) @(negedge clkin);
        check("arst_noreq", 32'(req_log.size()), 0);
        check("arst_req2", 32'(mem_req), 0);
        check("arst_valid2", 32'(ch_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bsx_stream_prefetch.md
Name: bsx_stream_prefetch

Overview:
- Sequences BS-X satellite stream page reads for both stream channels (0 = regs 0x218C/0x218A/0x218B group, 1 = 0x2192 group).
- Round-robin shares a single byte-wide memory read port between the channels.
- Prefetches stream bytes into a small per-channel FIFO, so SNES reads of the stream data register are served with no memory latency.
- Sits between the BS-X register block (page/load/pop events) and the cartridge memory arbiter.

Parameters:
- BASE_ADDR, 24'hE00000, memory base of the stream page area.
- DEPTH, 4, per-channel FIFO depth in bytes; power of two, minimum 2.
- START_OFF, 9'h048, first data byte offset within a page.

Ports:
- clkin  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- enable  in  1  BS-X mode active. When 0: no new mem_req issued, pops return 0x00.
- ch_load  in  2  per-channel one-cycle pulse. Latch ch_pageN, restart the stream.
- ch_page0  in  10  channel 0 page number.
- ch_page1  in  10  channel 1 page number.
- ch_pop  in  2  per-channel one-cycle pulse. Consume the head byte (SNES read rising edge).
- ch_data0  out  8  channel 0 head byte.
- ch_data1  out  8  channel 1 head byte.
- ch_valid  out  2  FIFO non-empty per channel.
- ch_underrun  out  2  sticky. A pop occurred while empty; cleared by ch_load of that channel.
- mem_req  out  1  read request.
- mem_addr  out  24  read address.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  8  read data.

Behaviour:
- Reset values:
  - All outputs 0; mem_addr 0.
  - FIFOs empty; both channels inactive; latched pages 0; fetch offsets START_OFF.
  - RR pointer favours channel 0.
- Channel state per channel:
  - active: latched page != 0.
  - fetch_off: 9-bit next offset to request.
  - done: fetch_off wrapped past 9'h1FF.
- ch_load[N]:
  - Latches ch_pageN, sets fetch_off = START_OFF, clears done, empties FIFO N, clears ch_underrun[N].
  - Marks any outstanding request for N as stale.
- Channel N needs data when: active, not done, FIFO occupancy + (outstanding for N ? 1 : 0) < DEPTH, and enable = 1.
- Controller states:
  - IDLE: if any channel needs data, grant round-robin (pointer's channel first, otherwise the other). Next cycle: mem_req = 1, mem_addr = BASE_ADDR + {page, fetch_off} (19 bits zero-extended). Go to WAIT.
  - WAIT: mem_req and mem_addr held stable until mem_ack.
    - On ack, if not stale: write mem_rdata to the granted FIFO, fetch_off += 1. If fetch_off was 9'h1FF, set done (no wrap).
    - On ack, if stale: data dropped, fetch_off unchanged.
    - Either way: mem_req drops the same edge, RR pointer moves to the other channel, return to IDLE.
    - At most one outstanding request.
- Latency:
  - Ack to ch_valid high: 1 clock.
  - Minimum request spacing: 2 clocks (IDLE, then WAIT).
- Pop:
  - Non-empty: head advances at the edge; ch_dataN shows the new head next cycle.
  - Empty: FIFO unchanged, ch_underrun[N] set, ch_dataN = 0x00.
  - ch_dataN = 0x00 whenever empty or enable = 0.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: both take effect; occupancy unchanged. Legal when full.
  - Load and pop same channel: load wins, pop ignored, no underrun.
  - Load and ack same channel: data treated as stale.
  - Load of the other channel during WAIT: does not disturb the current request.
- enable falling during WAIT: the request completes normally; no further requests are issued.
- rst_n asserted mid-request: mem_req low immediately (async). The memory arbiter drops the transaction.
- Widths:
  - fetch_off is 9-bit and never wraps; once done is set, no further fetches for that channel.
  - Occupancy counter is log2(DEPTH)+1 bits.

Test Plan:
- Single channel fill:
  - Stimulus: load ch0 page 0x005, mem_ack 2 cycles after each req.
  - Required: mem_addr sequence E00A48, E00A49, E00A4A, E00A4B. mem_req stays low after 4 with ch_valid[0] = 1. Pop once → one further request at E00A4C.
- Round-robin:
  - Stimulus: load ch0 page 0x001, ch1 page 0x002 same cycle.
  - Required: request addresses alternate E00248, E00448, E00249, E00449…
- Stale flush:
  - Stimulus: load ch1 page 0x003; during WAIT for E00648, load ch1 page 0x004; ack with 0x5A.
  - Required: 0x5A discarded, ch_valid[1] = 0. Next request E00848.
- Underrun:
  - Stimulus: pop ch0 while empty.
  - Required: ch_data0 = 0x00, ch_underrun[0] = 1. Load ch0 → underrun cleared.
- End of page:
  - Stimulus: preload fetch to offset 0x1FE, pop continuously.
  - Required: requests for offsets 1FE and 1FF only. Then no mem_req. Subsequent pops after drain flag underrun.
- Reset mid-WAIT:
  - Stimulus: assert rst_n low while mem_req = 1.
  - Required: mem_req = 0 with no clock edge; all FIFOs empty; page 0 on release; no requests issued.
